// File: rtl/rv32_id_alu_ctrl_if.sv
// IF/ID -> ID/EX handshake and decoded-payload bundle for the RV32I ALU control stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface rv32_id_alu_ctrl_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        ex_ready;
   logic        flush;
   logic        ex_valid;
   logic [3:0]  ex_alu_opsel;
   logic [1:0]  ex_opa_sel;
   logic        ex_use_imm;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic        ex_illegal;
   logic [31:0] ex_pc;

   modport slave (
      input  if_valid, if_instr, if_pc, ex_ready, flush,
      output id_ready, ex_valid, ex_alu_opsel, ex_opa_sel, ex_use_imm, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_rd_we, ex_illegal, ex_pc
   );

   modport master (
      output if_valid, if_instr, if_pc, ex_ready, flush,
      input  id_ready, ex_valid, ex_alu_opsel, ex_opa_sel, ex_use_imm, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_rd_we, ex_illegal, ex_pc
   );
endinterface

// File: rtl/rv32_id_alu_ctrl.sv
// Decodes RV32I OP / OP-IMM / LUI / AUIPC into ALU opcode, operand selects and immediate,
// and holds the result in the ID/EX register behind a valid/ready handshake with flush.
module rv32_id_alu_ctrl #(
   parameter int XLEN = 32
) (
   input logic            clk,
   input logic            rst,
   rv32_id_alu_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR    = 4'd3,
      ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA   = 4'd7,
      ALU_ADDI = 4'd8,  ALU_ANDI = 4'd9,  ALU_ORI  = 4'd10, ALU_XORI  = 4'd11,
      ALU_SLT  = 4'd12, ALU_SLTU = 4'd13, ALU_SLTI = 4'd14, ALU_SLTIU = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'd0,
      OPA_PC   = 2'd1,
      OPA_ZERO = 2'd2
   } opa_sel_e;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   alu_op_e         dec_opsel;
   opa_sel_e        dec_opa;
   logic            dec_use_imm;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [4:0]      dec_rd;
   logic            dec_we;
   logic            dec_ill;

   assign opcode = bus.if_instr[6:0];
   assign funct3 = bus.if_instr[14:12];
   assign funct7 = bus.if_instr[31:25];

   always_comb begin
      dec_opsel   = ALU_ADD;
      dec_opa     = OPA_RS1;
      dec_use_imm = 1'b0;
      dec_imm     = '0;
      dec_rs1     = bus.if_instr[19:15];
      dec_rs2     = '0;
      dec_rd      = bus.if_instr[11:7];
      dec_ill     = 1'b0;
      dec_we      = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_rs2 = bus.if_instr[24:20];
            case (funct3)
               3'b000:  dec_opsel = funct7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  dec_opsel = ALU_SLL;
               3'b010:  dec_opsel = ALU_SLT;
               3'b011:  dec_opsel = ALU_SLTU;
               3'b100:  dec_opsel = ALU_XOR;
               3'b101:  dec_opsel = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  dec_opsel = ALU_OR;
               default: dec_opsel = ALU_AND;
            endcase
            // Only ADD/SUB and SRL/SRA have a funct7=0x20 alternate form.
            if (!((funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
               dec_ill = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_use_imm = 1'b1;
            dec_imm     = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
            case (funct3)
               3'b000: dec_opsel = ALU_ADDI;
               3'b001: begin
                  dec_opsel = ALU_SLL;
                  dec_imm   = {{(XLEN-5){1'b0}}, bus.if_instr[24:20]};
                  dec_ill   = (funct7 != 7'h00);
               end
               3'b010: dec_opsel = ALU_SLTI;
               3'b011: dec_opsel = ALU_SLTIU;
               3'b100: dec_opsel = ALU_XORI;
               3'b101: begin
                  dec_opsel = funct7[5] ? ALU_SRA : ALU_SRL;
                  dec_imm   = {{(XLEN-5){1'b0}}, bus.if_instr[24:20]};
                  dec_ill   = (funct7 != 7'h00) && (funct7 != 7'h20);
               end
               3'b110:  dec_opsel = ALU_ORI;
               default: dec_opsel = ALU_ANDI;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_opsel   = ALU_ADDI;
            dec_opa     = (opcode == OPC_LUI) ? OPA_ZERO : OPA_PC;
            dec_use_imm = 1'b1;
            dec_imm     = {bus.if_instr[31:12], 12'b0};
            dec_rs1     = '0;
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal encodings carry a neutral payload so nothing downstream reads stale operands.
      if (dec_ill) begin
         dec_opsel   = ALU_ADD;
         dec_opa     = OPA_RS1;
         dec_use_imm = 1'b0;
         dec_imm     = '0;
         dec_rs1     = '0;
         dec_rs2     = '0;
      end
      dec_we = !dec_ill && (dec_rd != 5'd0);
   end

   assign bus.id_ready = !bus.ex_valid || bus.ex_ready;

   // Flush beats load and stall; payload only moves when a real instruction is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ex_valid     <= 1'b0;
         bus.ex_alu_opsel <= '0;
         bus.ex_opa_sel   <= '0;
         bus.ex_use_imm   <= 1'b0;
         bus.ex_imm       <= '0;
         bus.ex_rs1       <= '0;
         bus.ex_rs2       <= '0;
         bus.ex_rd        <= '0;
         bus.ex_rd_we     <= 1'b0;
         bus.ex_illegal   <= 1'b0;
         bus.ex_pc        <= '0;
      end else if (bus.flush) begin
         bus.ex_valid <= 1'b0;
      end else if (bus.id_ready) begin
         bus.ex_valid <= bus.if_valid;
         if (bus.if_valid) begin
            bus.ex_alu_opsel <= dec_opsel;
            bus.ex_opa_sel   <= dec_opa;
            bus.ex_use_imm   <= dec_use_imm;
            bus.ex_imm       <= dec_imm;
            bus.ex_rs1       <= dec_rs1;
            bus.ex_rs2       <= dec_rs2;
            bus.ex_rd        <= dec_rd;
            bus.ex_rd_we     <= dec_we;
            bus.ex_illegal   <= dec_ill;
            bus.ex_pc        <= bus.if_pc;
         end
      end
   end

endmodule
